// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int FREQ_MHZ   = 12,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int DIV   = (FREQ_MHZ * 1000000) / BAUDS;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);
  localparam logic [PTR_W:0]   DEPTH   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (reset_i) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rx_i};
  end

  assign rx_s = sync_q[1];

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q;
`endif

  // NOTE: sequential state is assigned with <= so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            cnt_q   <= HALF_M1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!rx_s) begin
            cnt_q     <= FULL_M1;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q   <= {rx_s, shift_q[7:1]};
            cnt_q     <= FULL_M1;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            par_bad_q <= rx_s ^ (^shift_q);
            cnt_q     <= FULL_M1;
            state_q   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          // Returning to IDLE at the mid-stop sample lets a following start edge be caught at once.
          if (cnt_q != '0) cnt_q   <= cnt_q - CNT_W'(1);
          else             state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic stop_hit;
  logic byte_ok;

  assign stop_hit    = (state_q == S_STOP) && (cnt_q == '0);
  assign frame_err_o = stop_hit && !rx_s;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = stop_hit && rx_s && par_bad_q;
  assign byte_ok      = stop_hit && rx_s && !par_bad_q;
`else
  assign parity_err_o = 1'b0;
  assign byte_ok      = stop_hit && rx_s;
`endif

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             full;
  logic             push;
  logic             pop;

  assign valid_o   = (count_q != '0);
  assign full      = (count_q == DEPTH);
  assign pop       = valid_o && ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
  assign push      = byte_ok && (!full || pop);
  assign overrun_o = byte_ok && full && !pop;
  assign data_o    = valid_o ? mem_q[rd_ptr_q] : 8'h00;

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: storage has no reset; entries are only observed after a push makes them valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic, each cycle
// compared against a timetable model of the receiver and a queue model of the FIFO.
module tb_uart_rx;

  localparam int DIV = 104;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR        = 1'b1;
  localparam int STOP_OFF   = 1092;
  localparam int VALID_OFF  = 1093;
`else
  localparam bit PAR        = 1'b0;
  localparam int STOP_OFF   = 988;
  localparam int VALID_OFF  = 989;
`endif

  logic       clk = 1'b0;
  logic       reset_i;
  logic       rx_i;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;

  uart_rx #(
    .FREQ_MHZ  (12),
    .BAUDS     (115200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Receiver model: line delayed by two cycles, then sampled on a fixed timetable from T0.
  bit         m_s0 = 1'b1;
  bit         m_s1 = 1'b1;
  bit         m_busy = 1'b0;
  int         m_t0;
  logic [7:0] m_byte;
  bit         m_par;
  logic [7:0] m_q[$];

  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int fe_cyc = 0, pe_cyc = 0, ov_cyc = 0, vrise_cyc = 0;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin : model
    bit         rx_s, e_fe, e_pe, e_ov, push, pop, e_valid;
    int         d, k;
    logic [7:0] e_data;
    if (reset_i) begin
      m_q.delete();
      m_busy     = 1'b0;
      m_s0       = 1'b1;
      m_s1       = 1'b1;
      prev_valid = 1'b0;
    end else begin
      rx_s    = m_s1;
      e_fe    = 1'b0;
      e_pe    = 1'b0;
      e_ov    = 1'b0;
      push    = 1'b0;
      e_valid = (m_q.size() != 0);
      e_data  = e_valid ? m_q[0] : 8'h00;
      pop     = e_valid && ready_i;
      if (!m_busy) begin
        if (!rx_s) begin
          m_busy = 1'b1;
          m_t0   = cyc;
        end
      end else begin
        d = cyc - m_t0;
        if (d == DIV / 2) begin
          if (rx_s) m_busy = 1'b0;
        end else if (d > DIV / 2 && (d - DIV / 2) % DIV == 0) begin
          k = (d - DIV / 2) / DIV - 1;
          if (k < 8) begin
            m_byte[k] = rx_s;
          end else if (PAR && k == 8) begin
            m_par = rx_s;
          end else begin
            m_busy = 1'b0;
            if (!rx_s)                          e_fe = 1'b1;
            else if (PAR && (m_par != ^m_byte)) e_pe = 1'b1;
            else if (m_q.size() == 4 && !pop)   e_ov = 1'b1;
            else                                push = 1'b1;
          end
        end
      end
      check("valid_o", valid_o, e_valid);
      if (e_valid) check("data_o", data_o, e_data);
      check("frame_err_o", frame_err_o, e_fe);
      check("parity_err_o", parity_err_o, e_pe);
      check("overrun_o", overrun_o, e_ov);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(m_byte);
      if (frame_err_o === 1'b1)  begin fe_cnt++; fe_cyc = cyc; end
      if (parity_err_o === 1'b1) begin pe_cnt++; pe_cyc = cyc; end
      if (overrun_o === 1'b1)    begin ov_cnt++; ov_cyc = cyc; end
      if (valid_o === 1'b1 && !prev_valid) vrise_cyc = cyc;
      prev_valid = (valid_o === 1'b1);
      m_s1 = m_s0;
      m_s0 = rx_i;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input bit v, input int n);
    rx_i = v;
    repeat (n) tick();
  endtask

  int line_start;

  task automatic send(input logic [7:0] b, input bit stop_v, input bit par_flip);
    line_start = cyc;
    hold(1'b0, DIV);
    for (int i = 0; i < 8; i++) hold(b[i], DIV);
    if (PAR) hold((^b) ^ par_flip, DIV);
    hold(stop_v, DIV);
  endtask

  task automatic read_expect(input logic [7:0] b, input string nm);
    check({nm, "_valid"}, valid_o, 1'b1);
    check(nm, data_o, b);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  int t0;
  bit rnd = 1'b0;
  logic [7:0] pat[4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
  logic [7:0] ovp[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};

  initial begin
    reset_i = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    check("reset_valid", valid_o, 1'b0);
    check("reset_data", data_o, 8'h00);
    check("reset_frame_err", frame_err_o, 1'b0);
    check("reset_parity_err", parity_err_o, 1'b0);
    check("reset_overrun", overrun_o, 1'b0);

    // Single byte, first-write latency, single pop.
    send(8'h55, 1'b1, 1'b0);
    t0 = line_start + 2;
    hold(1'b1, 10);
    check("t1_valid_time", vrise_cyc - t0, VALID_OFF);
    check("t1_no_errors", fe_cnt + pe_cnt + ov_cnt, 0);
    read_expect(8'h55, "t1_data");
    check("t1_empty", valid_o, 1'b0);

    // Back-to-back frames with no idle gap.
    for (int i = 0; i < 4; i++) send(pat[i], 1'b1, 1'b0);
    hold(1'b1, 10);
    for (int i = 0; i < 4; i++) read_expect(pat[i], "t2_data");
    check("t2_empty", valid_o, 1'b0);

    // Overrun on the fifth byte.
    ov_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      send(ovp[i], 1'b1, 1'b0);
      t0 = line_start + 2;
    end
    hold(1'b1, 10);
    check("t3_overrun_count", ov_cnt, 1);
    check("t3_overrun_time", ov_cyc - t0, STOP_OFF);
    for (int i = 0; i < 4; i++) read_expect(ovp[i], "t3_data");
    check("t3_empty", valid_o, 1'b0);

    // Framing error, then recovery.
    fe_cnt = 0;
    send(8'hA5, 1'b0, 1'b0);
    t0 = line_start + 2;
    hold(1'b1, 2 * DIV);
    check("t4_frame_err_count", fe_cnt, 1);
    check("t4_frame_err_time", fe_cyc - t0, STOP_OFF);
    check("t4_no_write", valid_o, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    hold(1'b1, 10);
    read_expect(8'h3C, "t4_next");

    // Start glitch shorter than half a bit.
    fe_cnt = 0; pe_cnt = 0; ov_cnt = 0;
    hold(1'b0, 20);
    hold(1'b1, 200);
    check("t5_glitch_no_write", valid_o, 1'b0);
    check("t5_glitch_no_err", fe_cnt + pe_cnt + ov_cnt, 0);
    send(8'h66, 1'b1, 1'b0);
    hold(1'b1, 10);
    read_expect(8'h66, "t5_after_glitch");

    // Reset mid-frame with a byte already buffered.
    send(8'h42, 1'b1, 1'b0);
    hold(1'b1, 10);
    check("t5_buffered", valid_o, 1'b1);
    hold(1'b0, DIV);
    hold(1'b1, DIV);
    hold(1'b0, 2 * DIV);
    rx_i    = 1'b1;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    check("t5_rst_valid", valid_o, 1'b0);
    check("t5_rst_data", data_o, 8'h00);
    check("t5_rst_errs", {frame_err_o, parity_err_o, overrun_o}, 3'b000);
    hold(1'b1, 2 * DIV);
    send(8'h7E, 1'b1, 1'b0);
    hold(1'b1, 10);
    read_expect(8'h7E, "t5_after_reset");

`ifdef UART_RX_PARITY_EN
    send(8'h03, 1'b1, 1'b0);
    t0 = line_start + 2;
    hold(1'b1, 10);
    check("t6_valid_time", vrise_cyc - t0, 1093);
    read_expect(8'h03, "t6_data");
    pe_cnt = 0;
    send(8'h03, 1'b1, 1'b1);
    hold(1'b1, 10);
    check("t6_parity_err_count", pe_cnt, 1);
    check("t6_no_write", valid_o, 1'b0);
`endif

    // Randomized traffic with a sluggish consumer; the model checks every cycle.
    rnd = 1'b1;
    fork
      begin
        while (rnd) begin
          ready_i = ($urandom_range(0, 3) == 0);
          tick();
        end
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      bit         sv;
      bit         pf;
      int         gap;
      b   = 8'($urandom);
      sv  = ($urandom_range(0, 9) != 0);
      pf  = PAR && ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 3);
      send(b, sv, pf);
      if (!sv)          hold(1'b1, 2 * DIV);
      else if (gap > 0) hold(1'b1, gap * (DIV / 2));
    end
    hold(1'b1, 2 * DIV);
    rnd = 1'b0;
    tick();
    tick();
    ready_i = 1'b1;
    repeat (8) tick();
    ready_i = 1'b0;
    tick();
    check("rand_drained", valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
